// File: rtl/subbytes_seq.sv
// subbytes_seq: time-multiplexed AES SubBytes, LANES bytes per clock, valid/ready on both sides.
// Define SUBBYTES_SEQ_INV_EN to add the inv port and InvSubBytes tables.
module subbytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
`ifdef SUBBYTES_SEQ_INV_EN
  input  logic         inv,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] sb_data_out,
  output logic         busy
);
  localparam int NCYC = 16 / LANES;
  localparam int CW = NCYC > 1 ? $clog2(NCYC) : 1;
  localparam int W = 8 * LANES;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
`ifdef SUBBYTES_SEQ_INV_EN
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
  logic inv_q;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [127:0]  hold_q, sb_q;
  logic          out_valid_q, busy_q;
  logic [W-1:0]  seg_in, seg_d;
  int            off;
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end
  // byte cnt*LANES sits highest in the state, so slices are taken from the MSB end
  assign off = (NCYC - 1 - int'(cnt_q)) * W;
  assign seg_in = hold_q[off +: W];
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [7:0] b;
    assign b = seg_in[W-1-8*i -: 8];
`ifdef SUBBYTES_SEQ_INV_EN
    assign seg_d[W-1-8*i -: 8] = inv_q ? INV_SBOX[b] : SBOX[b];
`else
    assign seg_d[W-1-8*i -: 8] = SBOX[b];
`endif
  end
  assign in_ready = state_q == IDLE && !rst;
  assign out_valid = out_valid_q;
  assign sb_data_out = sb_q;
  assign busy = busy_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      out_valid_q <= 1'b0;
      sb_q <= '0;
      busy_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (in_valid) begin
        hold_q <= data_in;
`ifdef SUBBYTES_SEQ_INV_EN
        inv_q <= inv;
`endif
        cnt_q <= '0;
        busy_q <= 1'b1;
        state_q <= RUN;
      end
    end else if (state_q == RUN) begin
      sb_q[off +: W] <= seg_d;
      if (cnt_q == CW'(NCYC - 1)) begin
        state_q <= DONE;
        out_valid_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
      state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_subbytes_seq.sv
// tb_subbytes_seq: runs LANES = 1, 2, 4, 8, 16 side by side against an S-box model
// built from GF(2^8) inversion plus the affine map.
module tb_subbytes_seq;
  logic         clk = 1'b0;
  logic         rst, vin, ordy;
  logic [127:0] din;
  logic [4:0]   ir, ov, bz;
  logic [127:0] dout [5];
  logic [7:0]   sb [256];
  int           tests = 0;
  int           fails = 0;
`ifdef SUBBYTES_SEQ_INV_EN
  logic inv = 1'b0;
`endif
  always #5 clk = ~clk;
  for (genvar g = 0; g < 5; g++) begin : g_dut
    subbytes_seq #(.LANES(1 << g)) u_dut (
      .clk(clk),
      .rst(rst),
`ifdef SUBBYTES_SEQ_INV_EN
      .inv(inv),
`endif
      .in_valid(vin),
      .in_ready(ir[g]),
      .data_in(din),
      .out_valid(ov[g]),
      .out_ready(ordy),
      .sb_data_out(dout[g]),
      .busy(bz[g])
    );
  end
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(logic [7:0] x, int n);
    return (x << n) | (x >> (8 - n));
  endfunction
  function automatic logic [127:0] model(logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sb[d[127-8*i -: 8]];
    return r;
  endfunction
  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, o, e);
    end
  endtask
  task automatic wait_idle();
    for (int n = 0; n < 40 && ir != 5'h1f; n++) @(negedge clk);
    chk("idle_wait", 128'(ir), 128'h1f);
  endtask
  // Accepts d in all instances on one edge, then checks latency, result and the return to IDLE.
  task automatic run_block(input logic [127:0] d, input logic [127:0] e, input bit pulse);
    logic [4:0] seen = 5'h0;
    logic [4:0] pend = 5'h0;
    wait_idle();
    din = d;
    vin = 1'b1;
    @(posedge clk);
    #1 vin = 1'b0;
    for (int k = 1; k <= 24 && (seen != 5'h1f || pend != 5'h0); k++) begin
      @(posedge clk);
      #1;
      if (pulse && k == 1) begin
        vin = 1'b1;
        din = {16{8'h01}};
      end else if (pulse && k == 2) vin = 1'b0;
      for (int g = 0; g < 5; g++) begin
        if (pend[g]) begin
          chk($sformatf("post_hs_L%0d", 1 << g), {126'h0, ir[g], ov[g]}, 128'h2);
          pend[g] = 1'b0;
        end
        if (!seen[g] && ov[g]) begin
          seen[g] = 1'b1;
          chk($sformatf("lat_L%0d", 1 << g), 128'(k), 128'(16 >> g));
          chk($sformatf("data_L%0d", 1 << g), dout[g], e);
          pend[g] = ordy;
        end
      end
    end
    chk("all_done", 128'(seen), 128'h1f);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [127:0] d;
    for (int a = 0; a < 256; a++) begin
      logic [7:0] x = 8'h00;
      for (int y = 1; y < 256 && a != 0; y++) if (gmul(8'(a), 8'(y)) == 8'h01) x = 8'(y);
      sb[a] = x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
    end
    rst = 1'b1;
    vin = 1'b0;
    ordy = 1'b1;
    din = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 128'(ov), 128'h0);
    chk("rst_busy", 128'(bz), 128'h0);
    chk("rst_in_ready", 128'(ir), 128'h0);
    for (int g = 0; g < 5; g++) chk($sformatf("rst_dout_L%0d", 1 << g), dout[g], 128'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 128'(ir), 128'h1f);
    d = 128'h00112233445566778899aabbccddeeff;
    run_block(d, model(d), 1'b0);
    chk("kat_const", dout[2], 128'h638293c31bfc33f5c4eeacea4bc12816);
    for (int t = 0; t < 4; t++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      run_block(d, model(d), 1'b0);
    end
    d = {$urandom, $urandom, $urandom, $urandom};
    ordy = 1'b0;
    run_block(d, model(d), 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(ov), 128'h1f);
      chk("bp_busy", 128'(bz), 128'h1f);
      chk("bp_in_ready", 128'(ir), 128'h0);
      for (int g = 0; g < 5; g++) chk($sformatf("bp_dout_L%0d", 1 << g), dout[g], model(d));
    end
    ordy = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_ov", 128'(ov), 128'h0);
    chk("bp_release_busy", 128'(bz), 128'h0);
    chk("bp_release_ir", 128'(ir), 128'h1f);
    wait_idle();
    din = '1;
    vin = 1'b1;
    @(posedge clk);
    #1 vin = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ov", 128'(ov), 128'h0);
    chk("midrst_busy", 128'(bz), 128'h0);
    for (int g = 0; g < 5; g++) chk($sformatf("midrst_dout_L%0d", 1 << g), dout[g], 128'h0);
    rst = 1'b0;
    run_block(128'h0, model(128'h0), 1'b0);
    chk("zero_const", dout[2], {16{8'h63}});
    d = {$urandom, $urandom, $urandom, $urandom};
    run_block(d, model(d), 1'b1);
    run_block({16{8'h01}}, model({16{8'h01}}), 1'b0);
    chk("ones_const", dout[2], {16{8'h7c}});
`ifdef SUBBYTES_SEQ_INV_EN
    inv = 1'b1;
    run_block(128'h638293c31bfc33f5c4eeacea4bc12816, 128'h00112233445566778899aabbccddeeff, 1'b0);
    inv = 1'b0;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
